// File: rtl/csr_commit_ctrl.sv
// Commit-stage sequencer: arbitrates exception / interrupt / ertn / CSR write for the
// instruction in WB, strobes the csr block, then flushes and redirects fetch.
module csr_commit_ctrl #(
    parameter int         DRAIN_CYCLES = 2,
    parameter logic [5:0] ECODE_INT    = 6'h00,
    parameter bit         REFETCH_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    output logic        wb_commit,
    input  logic [31:0] wb_pc,
    input  logic        wb_excp,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_vaddr,
    input  logic        wb_ertn,
    input  logic        wb_csr_we,
    input  logic [13:0] wb_csr_addr,
    input  logic [31:0] wb_csr_wdata,
    input  logic [31:0] wb_csr_wmask,
    input  logic        interrupt,
    input  logic [31:0] exception_entry,
    input  logic [31:0] exception_return_entry,
    output logic        csr_we,
    output logic [13:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic [31:0] csr_wmask,
    output logic        csr_excp,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    output logic [31:0] csr_vaddr,
    output logic [31:0] csr_pc,
    output logic        ertn_flush,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // Handshake: an instruction commits (or traps) in the cycle wb_valid & wb_ready.
    // wb_ready is high only while IDLE and out of reset; nothing else is accepted.
    typedef enum logic [1:0] {IDLE, TRAP, REDIR, DRAIN} state_t;
    typedef enum logic [1:0] {K_EXC, K_ERTN, K_REFETCH} kind_t;

    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [31:0]   pc_q, pc_d;
    logic [5:0]    ecode_q, ecode_d;
    logic [8:0]    esub_q, esub_d;
    logic [31:0]   vaddr_q, vaddr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          is_refetch;

    assign wb_ready   = (state_q == IDLE) && rst_n;
    assign accept     = wb_valid && wb_ready;
    assign is_refetch = REFETCH_EN &&
                        (wb_csr_addr inside {14'h000, 14'h004, 14'h005, 14'h041, 14'h044, 14'h180});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kind_q  <= K_EXC;
            pc_q    <= '0;
            ecode_q <= '0;
            esub_q  <= '0;
            vaddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pc_q    <= pc_d;
            ecode_q <= ecode_d;
            esub_q  <= esub_d;
            vaddr_q <= vaddr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        pc_d           = pc_q;
        ecode_d        = ecode_q;
        esub_d         = esub_q;
        vaddr_d        = vaddr_q;
        cnt_d          = cnt_q;
        wb_commit      = 1'b0;
        csr_we         = 1'b0;
        csr_addr       = '0;
        csr_wdata      = '0;
        csr_wmask      = '0;
        csr_excp       = 1'b0;
        csr_ecode      = '0;
        csr_esubcode   = '0;
        csr_vaddr      = '0;
        csr_pc         = '0;
        ertn_flush     = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (wb_excp || interrupt) begin
                        // An interrupt cancels the instruction, including any CSR write.
                        kind_d  = K_EXC;
                        pc_d    = wb_pc;
                        ecode_d = wb_excp ? wb_ecode : ECODE_INT;
                        esub_d  = wb_excp ? wb_esubcode : 9'd0;
                        vaddr_d = wb_excp ? wb_vaddr : 32'd0;
                        state_d = TRAP;
                    end else if (wb_ertn) begin
                        wb_commit = 1'b1;
                        kind_d    = K_ERTN;
                        state_d   = TRAP;
                    end else begin
                        wb_commit = 1'b1;
                        csr_we    = wb_csr_we;
                        if (wb_csr_we) begin
                            csr_addr  = wb_csr_addr;
                            csr_wdata = wb_csr_wdata;
                            csr_wmask = wb_csr_wmask;
                        end
                        if (wb_csr_we && is_refetch) begin
                            kind_d  = K_REFETCH;
                            pc_d    = wb_pc;
                            state_d = TRAP;
                        end
                    end
                end
            end
            TRAP: begin
                flush = 1'b1;
                if (kind_q == K_EXC) begin
                    csr_excp     = 1'b1;
                    csr_ecode    = ecode_q;
                    csr_esubcode = esub_q;
                    csr_vaddr    = vaddr_q;
                    csr_pc       = pc_q;
                end
                ertn_flush = (kind_q == K_ERTN);
                state_d    = REDIR;
            end
            REDIR: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                case (kind_q)
                    K_EXC:   redirect_pc = exception_entry;
                    K_ERTN:  redirect_pc = exception_return_entry;
                    default: redirect_pc = pc_q + 32'd4;
                endcase
                cnt_d   = CW'(DRAIN_CYCLES);
                state_d = DRAIN;
            end
            DRAIN: begin
                flush = 1'b1;
                if (cnt_q <= CW'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Bench for csr_commit_ctrl: directed and random WB traffic, a cycle-timeline reference
// model feeding an expected queue, and a monitor comparing DUT outputs each cycle.
module tb_csr_commit_ctrl;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_excp, wb_ertn, wb_csr_we, interrupt;
    logic [31:0] wb_pc, wb_vaddr, wb_csr_wdata, wb_csr_wmask;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [13:0] wb_csr_addr;
    logic [31:0] exception_entry, exception_return_entry;
    logic        wb_ready, wb_commit, csr_we, csr_excp, ertn_flush, flush, redirect_valid;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata, csr_wmask, csr_vaddr, csr_pc, redirect_pc;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;

    csr_commit_ctrl #(.DRAIN_CYCLES(D), .ECODE_INT(6'h00), .REFETCH_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_commit(wb_commit), .wb_pc(wb_pc), .wb_excp(wb_excp), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr), .wb_ertn(wb_ertn),
        .wb_csr_we(wb_csr_we), .wb_csr_addr(wb_csr_addr), .wb_csr_wdata(wb_csr_wdata),
        .wb_csr_wmask(wb_csr_wmask), .interrupt(interrupt),
        .exception_entry(exception_entry), .exception_return_entry(exception_return_entry),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
        .csr_excp(csr_excp), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .csr_vaddr(csr_vaddr), .csr_pc(csr_pc), .ertn_flush(ertn_flush), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready, commit, we;
        logic [13:0] addr;
        logic [31:0] wdata, wmask;
        logic        excp;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] vaddr, pc;
        logic        ertn, flush, redir;
        logic [31:0] rpc;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles elapsed since a trap-class instruction was accepted.
    int          m_t = 0;
    int          m_kind = 0;
    logic [31:0] m_pc;
    logic [5:0]  m_ecode;
    logic [8:0]  m_esub;
    logic [31:0] m_vaddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit refetch_addr(input logic [13:0] a);
        return a inside {14'h000, 14'h004, 14'h005, 14'h041, 14'h044, 14'h180};
    endfunction

    task automatic model_cycle();
        exp_t e;
        e = '0;
        if (m_t == 0) begin
            e.ready = 1'b1;
            if (wb_valid) begin
                if (wb_excp || interrupt) begin
                    m_kind  = 0;
                    m_pc    = wb_pc;
                    m_ecode = wb_excp ? wb_ecode : 6'h00;
                    m_esub  = wb_excp ? wb_esubcode : 9'd0;
                    m_vaddr = wb_excp ? wb_vaddr : 32'd0;
                    m_t     = 1;
                end else if (wb_ertn) begin
                    e.commit = 1'b1;
                    m_kind   = 1;
                    m_t      = 1;
                end else begin
                    e.commit = 1'b1;
                    e.we     = wb_csr_we;
                    e.addr   = wb_csr_addr;
                    e.wdata  = wb_csr_wdata;
                    e.wmask  = wb_csr_wmask;
                    if (wb_csr_we && refetch_addr(wb_csr_addr)) begin
                        m_kind = 2;
                        m_pc   = wb_pc;
                        m_t    = 1;
                    end
                end
            end
        end else begin
            e.flush = 1'b1;
            if (m_t == 1) begin
                e.excp  = (m_kind == 0);
                e.ertn  = (m_kind == 1);
                e.ecode = m_ecode;
                e.esub  = m_esub;
                e.vaddr = m_vaddr;
                e.pc    = m_pc;
            end
            if (m_t == 2) begin
                e.redir = 1'b1;
                e.rpc   = (m_kind == 0) ? exception_entry :
                          (m_kind == 1) ? exception_return_entry : m_pc + 32'd4;
            end
            m_t = (m_t == 2 + D) ? 0 : m_t + 1;
        end
        exp_q.push_back(W'(e));
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_excp = 0; wb_ertn = 0; wb_csr_we = 0; interrupt = 0;
        wb_pc = 0; wb_vaddr = 0; wb_ecode = 0; wb_esubcode = 0;
        wb_csr_addr = 0; wb_csr_wdata = 0; wb_csr_wmask = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, wb_ready}, 0);
        chk({tag, "_commit"}, {31'd0, wb_commit}, 0);
        chk({tag, "_csr_we"}, {31'd0, csr_we}, 0);
        chk({tag, "_csr_excp"}, {31'd0, csr_excp}, 0);
        chk({tag, "_ertn_flush"}, {31'd0, ertn_flush}, 0);
        chk({tag, "_flush"}, {31'd0, flush}, 0);
        chk({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 0);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_t'(exp_q.pop_front());
            chk("wb_ready", {31'd0, wb_ready}, {31'd0, mon_e.ready});
            chk("wb_commit", {31'd0, wb_commit}, {31'd0, mon_e.commit});
            chk("csr_we", {31'd0, csr_we}, {31'd0, mon_e.we});
            chk("csr_excp", {31'd0, csr_excp}, {31'd0, mon_e.excp});
            chk("ertn_flush", {31'd0, ertn_flush}, {31'd0, mon_e.ertn});
            chk("flush", {31'd0, flush}, {31'd0, mon_e.flush});
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, mon_e.redir});
            if (mon_e.we) begin
                chk("csr_addr", {18'd0, csr_addr}, {18'd0, mon_e.addr});
                chk("csr_wdata", csr_wdata, mon_e.wdata);
                chk("csr_wmask", csr_wmask, mon_e.wmask);
            end
            if (mon_e.excp) begin
                chk("csr_ecode", {26'd0, csr_ecode}, {26'd0, mon_e.ecode});
                chk("csr_esubcode", {23'd0, csr_esubcode}, {23'd0, mon_e.esub});
                chk("csr_vaddr", csr_vaddr, mon_e.vaddr);
                chk("csr_pc", csr_pc, mon_e.pc);
            end
            if (mon_e.redir) chk("redirect_pc", redirect_pc, mon_e.rpc);
        end
    end

    logic [13:0] addr_tab [8] = '{14'h000, 14'h004, 14'h005, 14'h041,
                                  14'h044, 14'h180, 14'h030, 14'h031};

    initial begin
        rst_n = 0;
        idle_inputs();
        exception_entry = 32'h1c008000;
        exception_return_entry = 32'h1c000200;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1;

        // plain csrwr SAVE0
        wb_valid = 1; wb_csr_we = 1; wb_csr_addr = 14'h030;
        wb_csr_wdata = 32'h1234; wb_csr_wmask = 32'hFFFFFFFF; wb_pc = 32'h1c000000;
        step();
        idle_inputs(); step();

        // synchronous exception
        wb_valid = 1; wb_excp = 1; wb_ecode = 6'h09; wb_pc = 32'h1c000100;
        wb_esubcode = 9'h1; wb_vaddr = 32'hdeadbeef;
        step();
        idle_inputs();
        repeat (D + 3) step();

        // interrupt while a csrwr sits in WB
        wb_valid = 1; interrupt = 1; wb_csr_we = 1; wb_csr_addr = 14'h030;
        wb_csr_wdata = 32'h55; wb_csr_wmask = 32'hFF; wb_pc = 32'h1c000140;
        step();
        idle_inputs();
        repeat (D + 3) step();

        // ertn
        wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1c000180;
        step();
        idle_inputs();
        repeat (D + 3) step();

        // exception beats ertn and csr write
        wb_valid = 1; wb_excp = 1; wb_ertn = 1; wb_csr_we = 1; wb_ecode = 6'h0b;
        wb_pc = 32'h1c000300;
        step();
        idle_inputs();
        repeat (D + 3) step();

        // refetch CSR write at top of address space wraps to 0
        wb_valid = 1; wb_csr_we = 1; wb_csr_addr = 14'h000; wb_csr_wdata = 32'h8;
        wb_csr_wmask = 32'hFFFFFFFF; wb_pc = 32'hFFFFFFFC;
        step();
        idle_inputs();
        repeat (D + 3) step();

        // interrupt with no instruction in WB is not taken
        interrupt = 1;
        repeat (3) step();
        idle_inputs();

        // reset asserted while in REDIR
        wb_valid = 1; wb_excp = 1; wb_ecode = 6'h09; wb_pc = 32'h1c000400;
        step();
        idle_inputs();
        step();
        #2;
        rst_n = 0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        m_t = 0;
        exp_q.delete();
        rst_n = 1;
        step();

        // randomized traffic, including junk driven while the sequencer is busy
        for (int i = 0; i < 400; i++) begin
            wb_valid     = ($urandom_range(0, 3) != 0);
            wb_excp      = ($urandom_range(0, 9) == 0);
            interrupt    = ($urandom_range(0, 11) == 0);
            wb_ertn      = ($urandom_range(0, 9) == 0);
            wb_csr_we    = ($urandom_range(0, 1) == 1);
            wb_csr_addr  = addr_tab[$urandom_range(0, 7)];
            wb_csr_wdata = $urandom;
            wb_csr_wmask = $urandom;
            wb_pc        = $urandom & 32'hFFFFFFFC;
            wb_ecode     = 6'($urandom_range(0, 63));
            wb_esubcode  = 9'($urandom_range(0, 511));
            wb_vaddr     = $urandom;
            exception_entry        = $urandom & 32'hFFFFFFFC;
            exception_return_entry = $urandom & 32'hFFFFFFFC;
            step();
        end
        idle_inputs();
        repeat (D + 4) step();
        @(negedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
